// File: rtl/hyper_pipe_rx.sv
// hyper_pipe_rx
//   Receiving end of a hyper_reg retiming chain. The chain cannot be stalled
//   on a per-cycle basis, so this block absorbs valid-qualified words into a
//   first-word-fall-through FIFO. It presents them downstream with a
//   valid/ready handshake. It raises o_stall early enough that words already
//   in flight (up to LATENCY+1) still fit.
//
// Parameters
//   DATA_WIDTH  payload width
//   DEPTH       FIFO entries (power of 2, >= 2*(LATENCY+1))
//   LATENCY     round-trip register stages (forward data + stall return)
//
// Ports
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_valid     word present on i_data
//   i_data      incoming payload
//   o_stall     registered stop request back to the sender
//   o_valid     FIFO head valid
//   o_data      FIFO head payload (0 while empty)
//   i_ready     downstream accepts the head
//   o_overflow  sticky: a word was dropped because the FIFO was full
//
// Optional feature (macro HYPER_PIPE_RX_LEVEL_EN)
//   o_level      registered fill level
//   o_max_level  high-water mark of the fill level, cleared only by i_rst
module hyper_pipe_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_overflow
`ifdef HYPER_PIPE_RX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [$clog2(DEPTH):0] o_max_level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // Leaves room for the LATENCY+1 words that can still arrive after o_stall rises.
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - LATENCY - 1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * (LATENCY + 1))) begin : g_bad_params
    $error("hyper_pipe_rx: DEPTH must be a power of 2 and at least 2*(LATENCY+1)");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  stall_q, stall_d;
  logic                  ovf_q, ovf_d;
  logic                  not_empty, full, rd_fire, wr_en;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign rd_fire   = not_empty & i_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en     = i_valid & (~full | rd_fire);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    stall_d = (count_d >= STALL_TH);
    // A valid word that was not written was dropped.
    ovf_d   = ovf_q | (i_valid & ~wr_en);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is data only; stale contents are never visible because o_valid
  // and o_data are qualified by the count.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // FWFT head: derived from registered state only, so i_valid never reaches
  // o_valid combinationally, and reset forces both to 0 immediately.
  assign o_valid    = not_empty;
  assign o_data     = not_empty ? mem_q[rd_ptr_q] : '0;
  assign o_stall    = stall_q;
  assign o_overflow = ovf_q;

`ifdef HYPER_PIPE_RX_LEVEL_EN
  logic [CNT_W-1:0] level_q;
  logic [CNT_W-1:0] max_level_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q     <= '0;
      max_level_q <= '0;
    end else begin
      level_q     <= count_d;
      max_level_q <= (count_d > max_level_q) ? count_d : max_level_q;
    end
  end

  assign o_level     = level_q;
  assign o_max_level = max_level_q;
`endif

endmodule

// File: tb/tb_hyper_pipe_rx.sv
module tb_hyper_pipe_rx;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 16;
  localparam int LATENCY    = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_stall;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;
  logic                  o_overflow;
`ifdef HYPER_PIPE_RX_LEVEL_EN
  logic [CNT_W-1:0]      o_level;
  logic [CNT_W-1:0]      o_max_level;
`endif

  hyper_pipe_rx #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_stall    (o_stall),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
`ifdef HYPER_PIPE_RX_LEVEL_EN
    ,
    .o_level    (o_level),
    .o_max_level(o_max_level)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural model: a queue holding the stored words in order.
  logic [DATA_WIDTH-1:0] mq[$];
  bit m_ovf;
  bit m_stall;
  int m_max;
  bit m_rd;
  bit m_wr;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
      m_max   = 0;
    end else begin
      m_rd = (mq.size() != 0) && (i_ready === 1'b1);
      m_wr = (i_valid === 1'b1) && ((mq.size() < DEPTH) || m_rd);
      if ((i_valid === 1'b1) && !m_wr) m_ovf = 1'b1;
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back(i_data);
      m_stall = (mq.size() >= DEPTH - LATENCY - 1);
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [31:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : 32'h0;
    chk("model_valid", {31'b0, o_valid}, {31'b0, (mq.size() != 0)});
    chk("model_data", o_data, exp_data);
    chk("model_stall", {31'b0, o_stall}, {31'b0, m_stall});
    chk("model_overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
`ifdef HYPER_PIPE_RX_LEVEL_EN
    chk("model_level", 32'(o_level), 32'(mq.size()));
    chk("model_max_level", 32'(o_max_level), 32'(m_max));
`endif
  endtask

  // One cycle: compare everything against the model at the falling edge,
  // then return just after the next rising edge, ready to drive.
  task automatic tick();
    @(negedge i_clk);
    cmp_model();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    i_ready = 1'b0;
    for (int k = 1; k <= n; k++) begin
      i_valid = 1'b1;
      i_data  = base + 32'(k);
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    do_reset();

    // Reset state
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_overflow", {31'b0, o_overflow}, 32'd0);

    // 1: single word, FWFT latency of one cycle
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'hA5A5_0001;
    tick();
    i_valid = 1'b0;
    chk("t1_valid", {31'b0, o_valid}, 32'd1);
    chk("t1_data", o_data, 32'hA5A5_0001);
    tick();
    chk("t1_valid_after", {31'b0, o_valid}, 32'd0);
    chk("t1_stall", {31'b0, o_stall}, 32'd0);

    // 2: stall threshold and in-order drain
    i_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      i_valid = 1'b1;
      i_data  = 32'(k);
      tick();
      if (k == 10) chk("t2_stall_10", {31'b0, o_stall}, 32'd0);
      if (k == 11) chk("t2_stall_11", {31'b0, o_stall}, 32'd1);
    end
    i_valid = 1'b0;
    chk("t2_overflow", {31'b0, o_overflow}, 32'd0);
`ifdef HYPER_PIPE_RX_LEVEL_EN
    chk("t2_level", 32'(o_level), 32'd16);
`endif
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("t2_drain_data", o_data, 32'(k));
      tick();
      if (k == 5) chk("t2_stall_cnt11", {31'b0, o_stall}, 32'd1);
      if (k == 6) chk("t2_stall_cnt10", {31'b0, o_stall}, 32'd0);
    end
    chk("t2_empty", {31'b0, o_valid}, 32'd0);

    // 3: drop on full, sticky overflow
    fill(16, 32'd100);
    i_valid = 1'b1;
    i_data  = 32'h0000_DEAD;
    tick();
    i_valid = 1'b0;
    chk("t3_overflow", {31'b0, o_overflow}, 32'd1);
    tick();
    chk("t3_overflow_sticky", {31'b0, o_overflow}, 32'd1);
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("t3_drain_data", o_data, 32'd100 + 32'(k));
      tick();
    end
    chk("t3_empty", {31'b0, o_valid}, 32'd0);
    chk("t3_overflow_end", {31'b0, o_overflow}, 32'd1);

    // 4: full with simultaneous write and read, across pointer wrap
    do_reset();
    fill(16, 32'd200);
    i_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      i_valid = 1'b1;
      i_data  = 32'd300 + 32'(j);
      chk("t4_head", o_data, (j < 16) ? 32'd201 + 32'(j) : 32'd300 + 32'(j - 16));
      tick();
    end
    i_valid = 1'b0;
    chk("t4_overflow", {31'b0, o_overflow}, 32'd0);
    chk("t4_stall", {31'b0, o_stall}, 32'd1);
`ifdef HYPER_PIPE_RX_LEVEL_EN
    chk("t4_level", 32'(o_level), 32'd16);
`endif
    for (int j = 4; j < 20; j++) begin
      chk("t4_drain", o_data, 32'd300 + 32'(j));
      tick();
    end
    chk("t4_empty", {31'b0, o_valid}, 32'd0);

    // Mixed traffic with toggling ready, checked by the model only
    for (int j = 0; j < 40; j++) begin
      i_valid = (j % 3) != 0;
      i_ready = (j % 2) == 1;
      i_data  = 32'h0BAD_0000 + 32'(j);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int j = 0; j < 20; j++) tick();

    // 5: asynchronous reset mid-cycle with words stored
    do_reset();
    fill(8, 32'd500);
    chk("t5_pre_valid", {31'b0, o_valid}, 32'd1);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("t5_rst_data", o_data, 32'd0);
    chk("t5_rst_stall", {31'b0, o_stall}, 32'd0);
    tick();
    i_rst   = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h0000_1234;
    tick();
    i_valid = 1'b0;
    chk("t5_first_valid", {31'b0, o_valid}, 32'd1);
    chk("t5_first_data", o_data, 32'h0000_1234);
    tick();
    chk("t5_after_valid", {31'b0, o_valid}, 32'd0);

`ifdef HYPER_PIPE_RX_LEVEL_EN
    // 6: level and high-water mark
    do_reset();
    fill(13, 32'd700);
    i_ready = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    i_ready = 1'b0;
    chk("t6_level", 32'(o_level), 32'd2);
    chk("t6_max_level", 32'(o_max_level), 32'd13);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_level", 32'(o_level), 32'd0);
    chk("t6_rst_max_level", 32'(o_max_level), 32'd0);
    tick();
    i_rst = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
